braille_player: RTL and testbench
=================================

# braille_player

Transmit-side counterpart of the Braille display path: accepts letter codes from the switches, buffers up to DEPTH letters, and on command plays them back one cell at a time as 6-dot Braille patterns on LEDs (tactile/visual actuator). Each cell is held for DWELL cycles, followed by a blank GAP. Sits between the board switch/key inputs and the LEDR bank, alongside the existing Braille-to-7-segment decoder.

## Interface
- DEPTH, 4, letter buffer entries (power of two, ≥2)
- DWELL, 25_000_000, clock cycles each cell is shown (≥1)
- GAP, 5_000_000, blank cycles after each cell (≥0; 0 = no blank)
- CLOCK_50  in  1  system clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- LETTER  in  5  0 = space, 1–26 = a–z, 27–31 = invalid
- WR  in  1  sync write strobe; appends LETTER when high for a cycle
- START  in  1  begin playback of buffered letters
- CLR  in  1  empty buffer / abort playback
- LEDR  out  6  dot pattern; bit i = dot i+1
- BUSY  out  1  high while playing
- DONE  out  1  one-cycle pulse at end of playback
- FULL  out  1  count == DEPTH
- COUNT  out  $clog2(DEPTH)+1  letters buffered

## Operation
- Reset: buffer empty, COUNT=0, FULL=0, LEDR=0, BUSY=0, DONE=0, state IDLE.
- Letter map, a–j: a=0x01 b=0x03 c=0x09 d=0x19 e=0x11 f=0x0B g=0x1B h=0x13 i=0x0A j=0x1A.
- k–t = a–j OR 0x04.
- u,v,x,y,z = a–e OR 0x24; w = 0x3A.
- Space = 0x00; invalid = 0x3F (all dots, error marker).
- WR in IDLE and not FULL: store LETTER at index COUNT; COUNT+1. WR while FULL, BUSY, or with START/CLR in same cycle: ignored.
- States: IDLE → SHOW → GAP → SHOW … → IDLE. Internal cycle counter and play index.
- IDLE: START with COUNT>0 → SHOW, index 0. START with COUNT=0 → DONE pulse next cycle, stay IDLE.
- SHOW: LEDR = pattern[index] for exactly DWELL cycles, then GAP (or, if GAP=0, next SHOW / end).
- GAP: LEDR=0 for GAP cycles. Then, if index < COUNT−1: index+1 → SHOW; else → IDLE with DONE.
- Buffer contents retained after playback; START again replays.
- CLR: highest priority. In IDLE, COUNT→0. In SHOW/GAP: abort to IDLE, LEDR=0, COUNT→0, no DONE.
- START while BUSY: ignored.
- RST mid-playback: immediate return to reset values, no DONE.

## Timing
- START sampled at edge t → BUSY=1 and LEDR=pattern[0] from t+1.
- Cell k visible cycles t+1+k·(DWELL+GAP) … +DWELL−1.
- Final edge: BUSY falls and DONE rises in the same cycle, at t+1+COUNT·(DWELL+GAP). DONE lasts one cycle.
- WR effect visible on COUNT/FULL the cycle after the strobe.
- LEDR, BUSY, DONE are registered outputs; no combinational path from inputs.

## Structure
- Package braille_pkg:
  - state enum (IDLE, SHOW, GAP)
  - letter code constants (SPACE=0, A=1 … Z=26)
  - 6-bit pattern constants, BLANK=0x00, ERR=0x3F
- Sub-module letter_to_braille: purely combinational 5→6 map, applied at buffer read. Reusable by a future self-check against the decoder.
- Counter width derived from max(DWELL, GAP).

## Test plan
Run with DWELL=4, GAP=2.
- Reset, write 'a'(1), 'b'(2), 'w'(23), START → LEDR 0x01×4, 0×2, 0x03×4, 0×2, 0x3A×4, 0×2; DONE pulse at cycle 19 after START, BUSY low same cycle.
- Write 5 letters with DEPTH=4 → COUNT=4, FULL=1, fifth ignored; playback shows only the first four.
- Write 0 and 30, START → LEDR 0x00 then 0x3F in the respective SHOW windows.
- START with empty buffer → DONE one cycle later, BUSY never high, LEDR stays 0.
- CLR during second SHOW → next cycle LEDR=0, BUSY=0, COUNT=0, no DONE. Likewise RST asserted asynchronously mid-GAP → all outputs 0 immediately.
- WR and START in the same IDLE cycle with COUNT=1 → write ignored, one cell played. WR during BUSY → COUNT unchanged.

Source files
------------

// File: rtl/braille_pkg.sv
// braille_pkg: shared states, letter codes and dot patterns for the Braille player
package braille_pkg;
  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;
  localparam logic [4:0] SPACE = 5'd0, A = 5'd1, B = 5'd2, C = 5'd3, D = 5'd4, E = 5'd5, F = 5'd6;
  localparam logic [4:0] G = 5'd7, H = 5'd8, I = 5'd9, J = 5'd10, K = 5'd11, L = 5'd12, M = 5'd13;
  localparam logic [4:0] N = 5'd14, O = 5'd15, P = 5'd16, Q = 5'd17, R = 5'd18, S = 5'd19, T = 5'd20;
  localparam logic [4:0] U = 5'd21, V = 5'd22, W = 5'd23, X = 5'd24, Y = 5'd25, Z = 5'd26;
  localparam logic [5:0] BLANK = 6'h00, ERR = 6'h3F, W_PAT = 6'h3A, ROW2 = 6'h04, ROW3 = 6'h24;
  // first decade a-j; later rows are built from it by adding dots 3 and 6
  function automatic logic [5:0] aj(input logic [3:0] m);
    case (m)
      4'd0: aj = 6'h01;
      4'd1: aj = 6'h03;
      4'd2: aj = 6'h09;
      4'd3: aj = 6'h19;
      4'd4: aj = 6'h11;
      4'd5: aj = 6'h0B;
      4'd6: aj = 6'h1B;
      4'd7: aj = 6'h13;
      4'd8: aj = 6'h0A;
      4'd9: aj = 6'h1A;
      default: aj = BLANK;
    endcase
  endfunction
endpackage

// File: rtl/letter_to_braille.sv
// letter_to_braille: combinational letter code to 6-dot pattern map
module letter_to_braille
  import braille_pkg::*;
(
  input  logic [4:0] letter,
  output logic [5:0] pattern
);
  logic [3:0] m;
  // w breaks the u-z run, so x-z index one step further back into a-e
  always_comb begin
    m = 4'(letter > W ? letter - 5'd22 : letter > T ? letter - 5'd21 : letter > J ? letter - 5'd11 : letter - 5'd1);
    pattern = letter == SPACE ? BLANK : letter > Z ? ERR : letter == W ? W_PAT :
              letter > T ? aj(m) | ROW3 : letter > J ? aj(m) | ROW2 : aj(m);
  end
endmodule

// File: rtl/braille_player.sv
// braille_player: buffers letters and plays them back as timed Braille cells on LEDs
module braille_player #(
  parameter int DEPTH = 4,
  parameter int DWELL = 25_000_000,
  parameter int GAP = 5_000_000
) (
  input  logic                     CLOCK_50,
  input  logic                     RST,
  input  logic [4:0]               LETTER,
  input  logic                     WR,
  input  logic                     START,
  input  logic                     CLR,
  output logic [5:0]               LEDR,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   COUNT
);
  import braille_pkg::*;
  localparam int AW = $clog2(DEPTH);
  localparam int MX = DWELL > GAP ? DWELL : GAP;
  localparam int CW = MX > 1 ? $clog2(MX) : 1;
  localparam logic [CW-1:0] DL = CW'(DWELL - 1);
  localparam logic [CW-1:0] GL = CW'(GAP > 0 ? GAP - 1 : 0);
  logic [4:0] mem [DEPTH];
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] idx, idx_n;
  logic done_n, last, we;
  logic [5:0] pat;
  assign FULL = COUNT == (AW+1)'(DEPTH);
  assign last = idx == AW'(COUNT - 1'b1);
  assign we = state == IDLE && WR && !FULL && !START && !CLR;
  // pattern of the cell about to be shown, so LEDR can be registered
  letter_to_braille u_map (.letter(mem[idx_n]), .pattern(pat));
  // next state: CLR aborts anything; SHOW and GAP each time out on their counter
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    done_n = 1'b0;
    if (CLR) begin
      state_n = IDLE;
      cnt_n = '0;
    end else if (state == IDLE) begin
      cnt_n = '0;
      if (START && COUNT != '0) begin
        state_n = SHOW;
        idx_n = '0;
      end else if (START) done_n = 1'b1;
    end else if ((state == SHOW && cnt == DL && GAP == 0) || (state == braille_pkg::GAP && cnt == GL)) begin
      cnt_n = '0;
      state_n = last ? IDLE : SHOW;
      idx_n = last ? idx : idx + 1'b1;
      done_n = last;
    end else if (state == SHOW && cnt == DL) begin
      cnt_n = '0;
      state_n = braille_pkg::GAP;
    end
  end
  // control state and registered outputs
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      COUNT <= '0;
      LEDR <= BLANK;
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      COUNT <= CLR ? '0 : we ? COUNT + 1'b1 : COUNT;
      LEDR <= state_n == SHOW ? pat : BLANK;
      BUSY <= state_n != IDLE;
      DONE <= done_n;
    end
  end
  // letter storage; validity is tracked by COUNT so no reset is needed
  always_ff @(posedge CLOCK_50) begin
    if (we) mem[COUNT[AW-1:0]] <= LETTER;
  end
endmodule

// File: tb/tb_braille_player.sv
// tb_braille_player: table-driven and scoreboard checks of Braille playback
module tb_braille_player;
  localparam int DW = 4, GP = 2;
  logic clk = 1'b0, rst = 1'b1, wr = 1'b0, start = 1'b0, clr = 1'b0;
  logic [4:0] letter = '0;
  logic [5:0] ledr;
  logic busy, done, full;
  logic [2:0] count;
  typedef struct packed {logic [5:0] led; logic busy; logic done;} exp_t;
  typedef struct {logic [4:0] letter; logic [5:0] pat;} vec_t;
  exp_t q[$];
  vec_t vt[12];
  int errors = 0, checks = 0;

  braille_player #(.DEPTH(4), .DWELL(DW), .GAP(GP)) dut (
    .CLOCK_50(clk), .RST(rst), .LETTER(letter), .WR(wr), .START(start), .CLR(clr),
    .LEDR(ledr), .BUSY(busy), .DONE(done), .FULL(full), .COUNT(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic wr1(input logic [4:0] l);
    letter = l;
    wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic push_cell(input logic [5:0] p);
    repeat (DW) q.push_back({p, 1'b1, 1'b0});
    repeat (GP) q.push_back({6'h00, 1'b1, 1'b0});
  endtask

  task automatic push_end();
    q.push_back({6'h00, 1'b0, 1'b1});
    q.push_back({6'h00, 1'b0, 1'b0});
  endtask

  task automatic play(input logic wr_with, input logic wr_during);
    exp_t e;
    wr = wr_with;
    start = 1'b1;
    tick();
    start = 1'b0;
    wr = 1'b0;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk("play", 16'({ledr, busy, done}), 16'(e));
      wr = wr_during && e.busy;
      tick();
    end
    wr = 1'b0;
  endtask

  initial begin
    vt[0] = '{5'd0, 6'h00};  vt[1] = '{5'd1, 6'h01};  vt[2] = '{5'd2, 6'h03};
    vt[3] = '{5'd10, 6'h1A}; vt[4] = '{5'd11, 6'h05}; vt[5] = '{5'd13, 6'h0D};
    vt[6] = '{5'd20, 6'h1E}; vt[7] = '{5'd21, 6'h25}; vt[8] = '{5'd23, 6'h3A};
    vt[9] = '{5'd24, 6'h2D}; vt[10] = '{5'd26, 6'h35}; vt[11] = '{5'd30, 6'h3F};
    #1;
    chk("reset", 16'({ledr, busy, done, full, count}), 16'h0);
    tick();
    rst = 1'b0;
    tick();
    wr1(5'd1); wr1(5'd2); wr1(5'd23);
    chk("count_abw", 16'(count), 16'd3);
    push_cell(6'h01); push_cell(6'h03); push_cell(6'h3A); push_end();
    play(1'b0, 1'b0);
    foreach (vt[i]) begin
      clear();
      wr1(vt[i].letter);
      push_cell(vt[i].pat); push_end();
      play(1'b0, 1'b0);
    end
    clear();
    wr1(5'd1); wr1(5'd2); wr1(5'd3);
    chk("full_before", 16'(full), 16'd0);
    wr1(5'd4); wr1(5'd5);
    chk("full_count", 16'({full, count}), 16'({1'b1, 3'd4}));
    push_cell(6'h01); push_cell(6'h03); push_cell(6'h09); push_cell(6'h19); push_end();
    play(1'b0, 1'b0);
    clear();
    push_end();
    play(1'b0, 1'b0);
    wr1(5'd1); wr1(5'd2); wr1(5'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("second_show", 16'({ledr, busy}), 16'({6'h03, 1'b1}));
    clear();
    chk("clr_abort", 16'({ledr, busy, done, count}), 16'h0);
    repeat (8) begin
      chk("clr_nodone", 16'({ledr, busy, done}), 16'h0);
      tick();
    end
    wr1(5'd1); wr1(5'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("in_gap", 16'({ledr, busy, count}), 16'({6'h00, 1'b1, 3'd2}));
    #2 rst = 1'b1;
    #1;
    chk("async_rst", 16'({ledr, busy, done, full, count}), 16'h0);
    tick();
    rst = 1'b0;
    repeat (3) begin
      tick();
      chk("rst_nodone", 16'({busy, done}), 16'h0);
    end
    wr1(5'd9);
    letter = 5'd2;
    push_cell(6'h0A); push_end();
    play(1'b1, 1'b0);
    chk("wr_with_start", 16'(count), 16'd1);
    clear();
    wr1(5'd1);
    letter = 5'd5;
    push_cell(6'h01); push_end();
    play(1'b0, 1'b1);
    chk("wr_busy", 16'(count), 16'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
